// File: rtl/bootrom_bus_bridge.sv
// bootrom_bus_bridge
// Slave adapter between the PicoRV32 native memory bus and the synchronous
// bootloader ROM window. Decodes the window, issues registered ROM reads,
// absorbs the ROM's one-cycle read latency, keeps a one-word sequential
// instruction prefetch buffer and flags writes into the read-only window.
module bootrom_bus_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          SIZE_BYTES  = 8192,
  parameter int          ADDR_W      = 13,
  parameter int          PREFETCH_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_enable,
  input  logic [31:0]       rom_rdata,
  output logic              wr_fault,
  output logic [31:0]       fault_addr
);

  // Word-offset width inside the window and the last word offset.
  localparam int              OFF_W    = ADDR_W - 2;
  localparam logic [31:0]     WIN_MASK = ~(32'(SIZE_BYTES) - 32'd1);
  localparam logic [OFF_W-1:0] LAST_OFF = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP,
    S_WRESP,
    S_PF_ISSUE,
    S_PF_CAPTURE
  } state_t;

  state_t            state;
  state_t            state_nx;

  // Captured request and prefetch buffer.
  logic [OFF_W-1:0]  req_off;
  logic              req_instr;
  logic              pf_valid;
  logic [OFF_W-1:0]  pf_tag;
  logic [31:0]       pf_data;

  // Decode helpers.
  logic [OFF_W-1:0]  offset;
  logic [OFF_W-1:0]  pf_next;
  logic              is_write;
  logic              pf_hit;
  logic              pf_due;

  // Next values of the registered outputs.
  logic              mem_ready_d;
  logic [31:0]       mem_rdata_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              rom_enable_d;
  logic              wr_fault_d;
  logic [31:0]       fault_addr_d;

  assign sel      = mem_valid && ((mem_addr & WIN_MASK) == BASE_ADDR);
  assign offset   = mem_addr[ADDR_W-1:2];
  assign is_write = (mem_wstrb != 4'b0000);
  assign pf_hit   = pf_valid && (pf_tag == offset);
  assign pf_next  = req_off + OFF_W'(1);

  // A prefetch follows only an instruction read, never runs past the last
  // window word, and is skipped when the buffer already holds that word.
  assign pf_due = (PREFETCH_EN != 0) && req_instr && (req_off != LAST_OFF) &&
                  !(pf_valid && (pf_tag == pf_next));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; requests are only looked at in IDLE, so anything that
  // arrives during a response or a prefetch simply waits with mem_valid high.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (sel) begin
          if (is_write)    state_nx = S_WRESP;
          else if (pf_hit) state_nx = S_RESP;
          else             state_nx = S_ISSUE;
        end
      end
      S_ISSUE:      state_nx = S_CAPTURE;
      S_CAPTURE:    state_nx = S_RESP;
      S_RESP:       state_nx = pf_due ? S_PF_ISSUE : S_IDLE;
      S_WRESP:      state_nx = S_IDLE;
      S_PF_ISSUE:   state_nx = S_PF_CAPTURE;
      S_PF_CAPTURE: state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Output decode: bus-facing outputs are registered, so their next values are
  // derived from the state being entered.
  always_comb begin
    mem_ready_d  = (state_nx == S_RESP) || (state_nx == S_WRESP);
    wr_fault_d   = (state_nx == S_WRESP);
    rom_enable_d = (state_nx == S_ISSUE) || (state_nx == S_PF_ISSUE);
    rom_addr_d   = rom_addr;
    mem_rdata_d  = mem_rdata;
    fault_addr_d = fault_addr;
    if (state_nx == S_ISSUE) begin
      rom_addr_d = {offset, 2'b00};
    end else if (state_nx == S_PF_ISSUE) begin
      rom_addr_d = {pf_next, 2'b00};
    end
    if (state == S_CAPTURE) begin
      mem_rdata_d = rom_rdata;
    end else if ((state == S_IDLE) && (state_nx == S_RESP)) begin
      mem_rdata_d = pf_data;
    end
    if (state_nx == S_WRESP) begin
      fault_addr_d = mem_addr;
    end
  end

  // Registered bus and ROM outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      rom_addr   <= '0;
      rom_enable <= 1'b0;
      wr_fault   <= 1'b0;
      fault_addr <= '0;
    end else begin
      mem_ready  <= mem_ready_d;
      mem_rdata  <= mem_rdata_d;
      rom_addr   <= rom_addr_d;
      rom_enable <= rom_enable_d;
      wr_fault   <= wr_fault_d;
      fault_addr <= fault_addr_d;
    end
  end

  // Request capture and prefetch buffer fill; the ROM never changes, so the
  // buffer is only cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_off   <= '0;
      req_instr <= 1'b0;
      pf_valid  <= 1'b0;
      pf_tag    <= '0;
      pf_data   <= '0;
    end else begin
      if ((state == S_IDLE) && sel) begin
        req_off   <= offset;
        req_instr <= mem_instr;
      end
      if (state == S_PF_CAPTURE) begin
        pf_valid <= 1'b1;
        pf_tag   <= pf_next;
        pf_data  <= rom_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bootrom_bus_bridge.sv
// tb_bootrom_bus_bridge
// Directed and random bus transactions against two bridges (prefetch on and
// off) backed by a behavioural ROM. Expected latency, data, fault reporting
// and the sequence of ROM word reads come from a transaction-level model.
module tb_bootrom_bus_bridge;

  localparam int WORDS = 2048;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b, sel_a, sel_b, en_a, en_b, wf_a, wf_b;
  logic [31:0] rdata_a, rdata_b, fa_a, fa_b, romd_a, romd_b;
  logic [12:0] ra_a, ra_b;

  logic [31:0] rom_mem [WORDS];
  logic [12:0] rom_log[$];
  logic [12:0] exp_log[$];

  int          n_vec = 0;
  int          n_err = 0;

  // Transaction-level model of the prefetch buffer of the prefetching bridge.
  bit          m_pf_valid;
  logic [10:0] m_pf_tag;
  int          extra_pending;

  always #5 clk = ~clk;

  bootrom_bus_bridge #(.PREFETCH_EN(1)) u_pf (
    .clk(clk), .resetn(resetn), .mem_valid(valid_a), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_ready(ready_a),
    .mem_rdata(rdata_a), .sel(sel_a), .rom_addr(ra_a), .rom_enable(en_a),
    .rom_rdata(romd_a), .wr_fault(wf_a), .fault_addr(fa_a)
  );

  bootrom_bus_bridge #(.PREFETCH_EN(0)) u_nopf (
    .clk(clk), .resetn(resetn), .mem_valid(valid_b), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_ready(ready_b),
    .mem_rdata(rdata_b), .sel(sel_b), .rom_addr(ra_b), .rom_enable(en_b),
    .rom_rdata(romd_b), .wr_fault(wf_b), .fault_addr(fa_b)
  );

  // Synchronous ROMs: data appears the cycle after an enabled edge.
  always @(posedge clk) begin
    if (en_a) romd_a <= rom_mem[ra_a[12:2]];
    if (en_b) romd_b <= rom_mem[ra_b[12:2]];
  end

  // Every ROM read issued by the prefetching bridge, in order.
  always @(negedge clk) begin
    if (en_a) rom_log.push_back(ra_a);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_log();
    check("romlog_len", rom_log.size(), exp_log.size());
    if (rom_log.size() == exp_log.size()) begin
      for (int i = 0; i < rom_log.size(); i++) check("romlog_addr", rom_log[i], exp_log[i]);
    end
    rom_log.delete();
    exp_log.delete();
  endtask

  // Idle cycles: no response may appear, and all pending ROM traffic settles.
  task automatic gap(input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (ready_a || ready_b) cnt++;
    end
    check("idle_ready", cnt, 0);
    check_log();
    extra_pending = 0;
  endtask

  // One bus transaction. b2b: presented right after the previous response.
  task automatic txn(input bit which, input logic [31:0] addr, input bit instr,
                     input logic [3:0] wstrb, input bit b2b);
    logic [10:0] off;
    bit          is_wr, hit, due, rdy;
    int          exp_lat, lat;
    off   = addr[12:2];
    is_wr = (wstrb != 4'h0);
    hit   = 1'b0;
    due   = 1'b0;
    if (!which && !is_wr) begin
      hit = m_pf_valid && (m_pf_tag == off);
      if (!hit) exp_log.push_back({off, 2'b00});
      due = instr && (off != 11'(WORDS - 1)) && !(m_pf_valid && (m_pf_tag == off + 11'd1));
      if (due) begin
        exp_log.push_back({off + 11'd1, 2'b00});
        m_pf_valid = 1'b1;
        m_pf_tag   = off + 11'd1;
      end
    end
    exp_lat = ((is_wr || hit) ? 1 : 3) + (b2b ? extra_pending : 0);

    mem_addr  = addr;
    mem_instr = instr;
    mem_wstrb = wstrb;
    if (which) valid_b = 1'b1; else valid_a = 1'b1;
    #1;
    check("sel", which ? sel_b : sel_a, 1'b1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      rdy = which ? ready_b : ready_a;
    end while (!rdy && lat < 20);
    check("latency", lat, exp_lat);
    check("wr_fault", which ? wf_b : wf_a, is_wr);
    if (is_wr) check("fault_addr", which ? fa_b : fa_a, addr);
    else       check("rdata", which ? rdata_b : rdata_a, rom_mem[off]);
    valid_a = 1'b0;
    valid_b = 1'b0;
    extra_pending = 1 + (due ? 2 : 0);
  endtask

  initial begin
    resetn    = 1'b0;
    valid_a   = 1'b0;
    valid_b   = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    m_pf_valid    = 1'b0;
    m_pf_tag      = '0;
    extra_pending = 0;
    for (int i = 0; i < WORDS; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h0000_0297;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", ready_a, 1'b0);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_rom_en", en_a, 1'b0);
    check("rst_rom_addr", ra_a, 32'h0);
    check("rst_wr_fault", wf_a, 1'b0);
    check("rst_fault_addr", fa_a, 32'h0);
    check("rst_sel", sel_a, 1'b0);
    check("rst_ready_b", ready_b, 1'b0);

    // Cold instruction fetch of word 0, then prefetch of word 1.
    txn(0, 32'h0001_0000, 1, 4'h0, 0);
    check("boot_word", rdata_a, 32'h0000_0297);
    gap(6);
    // Sequential fetch hits the buffer and prefetches word 2.
    txn(0, 32'h0001_0004, 1, 4'h0, 0);
    gap(6);
    // Write into the window: fault, no ROM traffic, buffer kept.
    txn(0, 32'h0001_0100, 0, 4'hF, 0);
    gap(4);
    check("fault_hold", fa_a, 32'h0001_0100);
    txn(0, 32'h0001_0008, 1, 4'h0, 0);
    gap(6);
    // Last window word: no prefetch past the end.
    txn(0, 32'h0001_1FFC, 1, 4'h0, 0);
    gap(6);

    // Just past the window: not selected, never answered.
    begin
      int cnt;
      cnt = 0;
      mem_addr  = 32'h0001_2000;
      mem_instr = 1'b1;
      mem_wstrb = 4'h0;
      valid_a   = 1'b1;
      #1;
      check("sel_outside", sel_a, 1'b0);
      repeat (8) begin
        @(posedge clk); #1;
        if (ready_a) cnt++;
      end
      check("outside_ready", cnt, 0);
      valid_a = 1'b0;
      gap(2);
    end

    // Data read: full latency, no prefetch.
    txn(0, 32'h0001_0010, 0, 4'h0, 0);
    gap(6);

    // Back-to-back: requests wait out the prefetch, then hit the new word.
    txn(0, 32'h0001_0020, 1, 4'h0, 0);
    txn(0, 32'h0001_0024, 1, 4'h0, 1);
    txn(0, 32'h0001_0028, 0, 4'h0, 1);
    gap(6);

    // Reset while the ROM word is being captured.
    mem_addr  = 32'h0001_0040;
    mem_instr = 1'b1;
    mem_wstrb = 4'h0;
    valid_a   = 1'b1;
    exp_log.push_back(13'h0040);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("midrst_ready", ready_a, 1'b0);
    check("midrst_rdata", rdata_a, 32'h0);
    check("midrst_rom_en", en_a, 1'b0);
    check("midrst_rom_addr", ra_a, 32'h0);
    check("midrst_wr_fault", wf_a, 1'b0);
    check("midrst_fault_addr", fa_a, 32'h0);
    valid_a       = 1'b0;
    m_pf_valid    = 1'b0;
    extra_pending = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    gap(3);
    txn(0, 32'h0001_0040, 1, 4'h0, 0);
    gap(6);
    // Word 10 was buffered before the reset; now it must miss.
    txn(0, 32'h0001_0028, 0, 4'h0, 0);
    gap(6);

    // Random mix of sequential/jumping fetches, data reads and writes.
    begin
      logic [10:0] roff;
      roff = '0;
      for (int i = 0; i < 40; i++) begin
        bit          b2b, wr, ins;
        logic [31:0] a;
        b2b = 1'($urandom_range(0, 1));
        wr  = ($urandom_range(0, 7) == 0);
        ins = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) roff = roff + 11'd1;
        else                           roff = 11'($urandom);
        a = 32'h0001_0000 | {19'b0, roff, 2'($urandom)};
        if (!b2b) gap(5);
        txn(0, a, ins, wr ? 4'($urandom_range(1, 15)) : 4'h0, b2b);
      end
      gap(6);
    end

    // Prefetch disabled: every read pays the full ROM latency.
    txn(1, 32'h0001_0000, 1, 4'h0, 0);
    gap(4);
    txn(1, 32'h0001_0004, 1, 4'h0, 0);
    txn(1, 32'h0001_0004, 1, 4'h0, 1);
    gap(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bootrom_bus_bridge.md
Name: bootrom_bus_bridge

Overview:
- Slave-side adapter between the PicoRV32 native memory bus and the synchronous 8KB bootloader ROM window at 0x10000-0x11FFF.
- Decodes the window, drives the ROM's addr/enable, and absorbs the ROM's one-cycle registered read latency.
- Returns data with a single-cycle mem_ready pulse.
- Adds a one-word sequential instruction prefetch buffer and reports illegal writes into the ROM window.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte base of the ROM window; aligned to SIZE_BYTES.
- SIZE_BYTES, 8192, window size; power of two.
- ADDR_W, 13, ROM byte-address width; equals log2(SIZE_BYTES).
- PREFETCH_EN, 1, 1 = sequential instruction prefetch enabled; 0 = buffer never filled.

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- mem_valid  input  1  bus request valid; held until mem_ready.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  byte address.
- mem_wstrb  input  4  byte write strobes; 0 = read.
- mem_ready  output  1  registered one-cycle completion pulse.
- mem_rdata  output  32  registered read data; valid while mem_ready=1.
- sel  output  1  combinational: mem_valid && (mem_addr & ~(SIZE_BYTES-1)) == BASE_ADDR.
- rom_addr  output  ADDR_W  registered ROM byte address; bits [1:0] always 0.
- rom_enable  output  1  registered ROM read enable.
- rom_rdata  input  32  ROM data; valid the cycle after rom_enable was high at a clock edge.
- wr_fault  output  1  one-cycle pulse on a write into the window.
- fault_addr  output  32  address of the last faulting write; holds until the next fault.

Behaviour:
- Reset (async, resetn=0): all outputs 0, state IDLE, pf_valid=0, pf_tag=0, pf_data=0.
- mem_addr[1:0] ignored for reads; offset = mem_addr[ADDR_W-1:2].
- States:
  - IDLE
  - ISSUE: rom_enable=1, rom_addr=offset<<2
  - CAPTURE: latch rom_rdata
  - RESP: mem_ready=1
  - WRESP: mem_ready=1, wr_fault=1
  - PF_ISSUE
  - PF_CAPTURE
- IDLE, sel=1, mem_wstrb!=0 -> WRESP.
  - Next cycle: mem_ready=1, wr_fault=1, fault_addr<=mem_addr.
  - No ROM access; prefetch buffer unchanged.
- IDLE, sel=1, read, pf_valid && pf_tag==offset -> RESP next cycle with mem_rdata=pf_data (1-cycle latency).
  - If instruction fetch: continue into prefetch of offset+1 as below.
- IDLE, sel=1, read, buffer miss -> ISSUE -> CAPTURE -> RESP.
  - Request seen at edge N; mem_ready high in cycle N+3.
  - mem_rdata = ROM word.
- RESP/WRESP always return to IDLE, or go to PF_ISSUE when a prefetch is due; mem_ready is never high two consecutive cycles.
- Prefetch is due when all hold:
  - PREFETCH_EN=1
  - completed read had mem_instr=1
  - offset+1 < SIZE_BYTES/4 (no prefetch past window end; no wrap to window start)
  - buffer does not already hold offset+1
- PF_ISSUE reads offset+1. PF_CAPTURE sets pf_data, pf_tag=offset+1, pf_valid=1, then -> IDLE.
- Requests arriving during PF_ISSUE/PF_CAPTURE are not accepted. The requester keeps mem_valid high and is decoded in IDLE after the prefetch completes, so it can hit the just-filled buffer.
- Data reads (mem_instr=0) may hit the buffer but never trigger a prefetch. ROM is read-only, so the buffer is never invalidated except by reset.
- sel=0: no response, no state change; another slave answers.
- mem_valid dropping mid-transaction (illegal for PicoRV32): the transaction still completes and mem_ready pulses once.
- rom_enable is high only in ISSUE/PF_ISSUE; otherwise rom_enable=0 and rom_addr holds its last value.
- Reset asserted mid-transaction: immediate return to IDLE, no mem_ready, buffer cleared.

Test Plan:
- Reset, then instr read 0x10000 (ROM word0=0x00000297) -> mem_ready at cycle N+3 with rdata 0x00000297; rom_enable pulses once for 0x0000, then once for 0x0004 (prefetch).
- After the previous scenario, instr read 0x10004 -> mem_ready at N+1 with ROM word1; rom_enable never asserts for 0x0004 during this read; prefetch of 0x0008 follows.
- sw to 0x10100, wstrb=4'hF -> mem_ready and wr_fault pulse at N+1, fault_addr=0x00010100, no rom_enable, next read of the prefetched word still hits.
- Instr read 0x11FFC -> data returned, no prefetch issued (rom_enable single pulse); read 0x12000 -> sel=0, no mem_ready ever.
- Data read (mem_instr=0) of 0x10010 -> 3-cycle response, no prefetch; PREFETCH_EN=0 build: every read 3-cycle latency.
- Assert resetn=0 in CAPTURE -> mem_ready stays 0, outputs 0 immediately; after release the same read is re-requested and completes with correct data.
